scan_mux: RTL and testbench

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux.sv | 132 +++++++++++++
 tb/tb_scan_mux.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// Channel scanner: fixed select or masked up/down scan with dwell.
// Output slice, index, valid and wrap are all registered.
module scan_mux #(
   parameter  int W  = 4,
   parameter  int N  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in_bus,
   input  logic [1:0]     mode,
   input  logic [SW-1:0]  sel,
   input  logic [N-1:0]   mask,
   input  logic [7:0]     dwell,
   input  logic           step_en,
   output logic [W-1:0]   out,
   output logic [SW-1:0]  ch,
   output logic           out_valid,
   output logic           wrap
);

   localparam logic [1:0] M_FIX  = 2'b00;
   localparam logic [1:0] M_UP   = 2'b01;
   localparam logic [1:0] M_DN   = 2'b10;
   localparam logic [1:0] M_HOLD = 2'b11;

   logic [W-1:0]  chan [N];
   logic [W-1:0]  out_q, out_d;
   logic [SW-1:0] ch_q, ch_d;
   logic          vld_q, vld_d;
   logic          wrap_q, wrap_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [1:0]    pm_q;
   logic [SW-1:0] nxt_up, nxt_dn;
   logic [SW-1:0] up_i, dn_i;
   logic          chg;
   logic          is_fix, is_scan, is_hold;
   logic          up;
   logic          sel_ok;

   for (genvar k = 0; k < N; k++) begin : g_chan
      assign chan[k] = in_bus[k*W +: W];
   end

   assign chg     = (mode != pm_q);
   assign is_fix  = (mode == M_FIX);
   assign is_hold = (mode == M_HOLD);
   assign is_scan = (mode == M_UP) || (mode == M_DN);
   assign up      = (mode == M_UP);
   assign sel_ok  = (int'(sel) < N);

   // nearest masked-in channel above and below the current one
   always_comb begin
      nxt_up = ch_q;
      nxt_dn = ch_q;
      up_i   = '0;
      dn_i   = '0;
      for (int i = N - 1; i >= 1; i--) begin
         up_i = SW'((int'(ch_q) + i) % N);
         dn_i = SW'((int'(ch_q) + N - i) % N);
         if (mask[up_i]) nxt_up = up_i;
         if (mask[dn_i]) nxt_dn = dn_i;
      end
   end

   // per-mode next state; mode change always clears dwell count
   always_comb begin
      ch_d   = ch_q;
      out_d  = out_q;
      vld_d  = vld_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      unique case (1'b1)
         is_fix: begin
            cnt_d = '0;
            if (sel_ok) begin
               ch_d  = sel;
               vld_d = 1'b1;
               out_d = chan[sel];
            end else begin
               vld_d = 1'b0;
            end
         end
         is_scan: begin
            if (mask == '0) begin
               vld_d = 1'b0;
            end else begin
               if (step_en && !chg) begin
                  if (cnt_q >= dwell) begin
                     cnt_d  = '0;
                     ch_d   = up ? nxt_up : nxt_dn;
                     wrap_d = up ? (ch_d <= ch_q)
                                 : (ch_d >= ch_q);
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
               vld_d = 1'b1;
               out_d = chan[ch_d];
            end
         end
         is_hold: begin
         end
      endcase
      if (chg) cnt_d = '0;
   end

   // state registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         ch_q   <= '0;
         vld_q  <= 1'b0;
         wrap_q <= 1'b0;
         cnt_q  <= '0;
         pm_q   <= M_FIX;
      end else begin
         out_q  <= out_d;
         ch_q   <= ch_d;
         vld_q  <= vld_d;
         wrap_q <= wrap_d;
         cnt_q  <= cnt_d;
         pm_q   <= mode;
      end
   end

   assign out       = out_q;
   assign ch        = ch_q;
   assign out_valid = vld_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: randomized stimulus against a behavioural model,
// plus directed scenarios and N=10 / N=6 range instances.
module tb_scan_mux;

   localparam int W  = 4;
   localparam int N  = 8;
   localparam int SW = 3;

   logic           clk     = 1'b0;
   logic           rst_n   = 1'b0;
   logic [N*W-1:0] in_bus  = '0;
   logic [1:0]     mode    = 2'b00;
   logic [SW-1:0]  sel     = '0;
   logic [N-1:0]   mask    = '0;
   logic [7:0]     dwell   = '0;
   logic           step_en = 1'b0;
   logic [W-1:0]   out;
   logic [SW-1:0]  ch;
   logic           out_valid;
   logic           wrap;

   logic [39:0] in10  = '0;
   logic [3:0]  sel10 = '0;
   logic [3:0]  out10;
   logic [3:0]  ch10;
   logic        vld10, wrap10;

   logic [23:0] in6  = '0;
   logic [2:0]  sel6 = '0;
   logic [3:0]  out6;
   logic [2:0]  ch6;
   logic        vld6, wrap6;

   int vecs = 0;
   int errs = 0;

   // model state
   int         m_ch;
   int         m_cnt;
   logic [W-1:0] m_out;
   bit         m_vld;
   bit         m_wrap;
   logic [1:0] m_pm;

   logic [8:0] dut_vec;
   assign dut_vec = {out, ch, out_valid, wrap};

   always #5 clk = ~clk;

   scan_mux #(.W(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .mode(mode),
      .sel(sel), .mask(mask), .dwell(dwell), .step_en(step_en),
      .out(out), .ch(ch), .out_valid(out_valid), .wrap(wrap)
   );

   scan_mux #(.W(4), .N(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .in_bus(in10), .mode(2'b00),
      .sel(sel10), .mask(10'h3FF), .dwell(8'd0), .step_en(1'b0),
      .out(out10), .ch(ch10), .out_valid(vld10), .wrap(wrap10)
   );

   scan_mux #(.W(4), .N(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .in_bus(in6), .mode(2'b00),
      .sel(sel6), .mask(6'h3F), .dwell(8'd0), .step_en(1'b0),
      .out(out6), .ch(ch6), .out_valid(vld6), .wrap(wrap6)
   );

   function automatic logic [W-1:0] slice(input logic [N*W-1:0] b,
                                          input int k);
      logic [N*W-1:0] s;
      s = b >> (k * W);
      return s[W-1:0];
   endfunction

   function automatic logic [8:0] m_vec();
      logic [SW-1:0] c;
      c = SW'(m_ch);
      return {m_out, c, m_vld, m_wrap};
   endfunction

   task automatic model_reset();
      m_ch   = 0;
      m_cnt  = 0;
      m_out  = '0;
      m_vld  = 0;
      m_wrap = 0;
      m_pm   = 2'b00;
   endtask

   // scan: search away from the old channel for the first enabled one
   task automatic model_step();
      int  old;
      int  idx;
      bit  chg;
      old    = m_ch;
      chg    = (mode != m_pm);
      m_wrap = 0;
      if (mode == 2'b00) begin
         m_cnt = 0;
         if (int'(sel) < N) begin
            m_ch  = int'(sel);
            m_vld = 1;
            m_out = slice(in_bus, m_ch);
         end else begin
            m_vld = 0;
         end
      end else if (mode == 2'b11) begin
         m_wrap = 0;
      end else if (mask == '0) begin
         m_vld = 0;
      end else begin
         if (step_en && !chg) begin
            if (m_cnt >= int'(dwell)) begin
               m_cnt = 0;
               for (int k = 1; k <= N; k++) begin
                  if (mode == 2'b01) idx = (old + k) % N;
                  else               idx = (old - k + N) % N;
                  if (mask[idx]) begin
                     m_ch = idx;
                     break;
                  end
               end
               if (mode == 2'b01) m_wrap = (m_ch <= old);
               else               m_wrap = (m_ch >= old);
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
         m_vld = 1;
         m_out = slice(in_bus, m_ch);
      end
      if (chg) m_cnt = 0;
      m_pm = mode;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      vecs++;
      if (dut_vec !== 9'd0) begin
         errs++;
         $display("FAIL reset got %h need 000", dut_vec);
      end
      vecs++;
      if ({out10, ch10, vld10, wrap10} !== 10'd0) begin
         errs++;
         $display("FAIL reset10 got %h need 000",
                  {out10, ch10, vld10, wrap10});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fixed();
      mode   = 2'b00;
      in_bus = 32'h7654_3210;
      sel    = 3'd5;
      tick();
      vecs++;
      if (dut_vec !== {4'h5, 3'd5, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL fixed_sel5 got %h need %h",
                  dut_vec, {4'h5, 3'd5, 1'b1, 1'b0});
      end
      sel = 3'd7;
      tick();
      vecs++;
      if (dut_vec !== {4'h7, 3'd7, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL fixed_sel7 got %h need %h",
                  dut_vec, {4'h7, 3'd7, 1'b1, 1'b0});
      end
      for (int i = 0; i < 12; i++) begin
         in_bus = $urandom;
         sel    = SW'($urandom_range(0, N - 1));
         tick();
         vecs++;
         if (dut_vec !== m_vec()) begin
            errs++;
            $display("FAIL fixed_rand[%0d] got %h need %h",
                     i, dut_vec, m_vec());
         end
      end
   endtask

   task automatic test_scan_up();
      mode = 2'b00;
      sel  = 3'd0;
      tick();
      mode    = 2'b01;
      mask    = 8'hFF;
      dwell   = 8'd0;
      step_en = 1'b1;
      tick();
      vecs++;
      if (ch !== 3'd0 || dut_vec !== m_vec()) begin
         errs++;
         $display("FAIL up_enter got %h need %h", dut_vec, m_vec());
      end
      for (int i = 1; i <= 8; i++) begin
         logic [SW-1:0] ec;
         in_bus = $urandom;
         ec     = SW'(i % 8);
         tick();
         vecs++;
         if (ch !== ec || wrap !== (i == 8) || dut_vec !== m_vec())
         begin
            errs++;
            $display("FAIL up_seq[%0d] got %h need ch %0d vec %h",
                     i, dut_vec, ec, m_vec());
         end
      end
   endtask

   task automatic test_scan_down();
      int exp_ch [12] = '{5, 5, 5, 2, 2, 2, 0, 0, 0, 5, 5, 5};
      mode = 2'b00;
      sel  = 3'd5;
      tick();
      mode    = 2'b10;
      mask    = 8'h25;
      dwell   = 8'd2;
      step_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         logic [SW-1:0] ec;
         in_bus = $urandom;
         ec     = SW'(exp_ch[i]);
         tick();
         vecs++;
         if (ch !== ec || wrap !== (i == 9) || dut_vec !== m_vec())
         begin
            errs++;
            $display("FAIL down_seq[%0d] got %h need ch %0d vec %h",
                     i, dut_vec, ec, m_vec());
         end
      end
   endtask

   task automatic test_mask_zero();
      logic [SW-1:0] held;
      mode    = 2'b01;
      mask    = 8'hFF;
      dwell   = 8'd1;
      step_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_bus = $urandom;
         tick();
         vecs++;
         if (dut_vec !== m_vec()) begin
            errs++;
            $display("FAIL mz_pre[%0d] got %h need %h",
                     i, dut_vec, m_vec());
         end
      end
      held   = SW'(m_ch);
      mask   = 8'h00;
      in_bus = $urandom;
      tick();
      vecs++;
      if (out_valid !== 1'b0 || ch !== held || wrap !== 1'b0) begin
         errs++;
         $display("FAIL mz_off got %h need ch %0d invalid",
                  dut_vec, held);
      end
      mask = 8'h08;
      for (int i = 0; i < 3; i++) begin
         in_bus = $urandom;
         tick();
         vecs++;
         if (dut_vec !== m_vec()) begin
            errs++;
            $display("FAIL mz_on[%0d] got %h need %h",
                     i, dut_vec, m_vec());
         end
      end
      vecs++;
      if (ch !== 3'd3 || out_valid !== 1'b1) begin
         errs++;
         $display("FAIL mz_land got ch %0d v %b need ch 3 v 1",
                  ch, out_valid);
      end
   endtask

   task automatic test_step_hold();
      mode = 2'b01;
      for (int i = 0; i < 30; i++) begin
         if (i == 20) mode = 2'b11;
         if (i < 20) begin
            mask    = N'($urandom_range(1, 255));
            dwell   = 8'($urandom_range(0, 3));
            step_en = ($urandom_range(0, 3) != 0);
         end else begin
            mask    = N'($urandom);
            step_en = 1'($urandom);
         end
         in_bus = $urandom;
         tick();
         vecs++;
         if (dut_vec !== m_vec()) begin
            errs++;
            $display("FAIL step_hold[%0d] got %h need %h",
                     i, dut_vec, m_vec());
         end
      end
   endtask

   task automatic test_dwell_change();
      mode    = 2'b01;
      mask    = 8'hFF;
      dwell   = 8'd6;
      step_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) dwell = 8'd1;
         in_bus = $urandom;
         tick();
         vecs++;
         if (dut_vec !== m_vec()) begin
            errs++;
            $display("FAIL dwell_chg[%0d] got %h need %h",
                     i, dut_vec, m_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            mask = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
         end
         if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 4));
         step_en = ($urandom_range(0, 3) != 0);
         sel     = SW'($urandom);
         in_bus  = $urandom;
         tick();
         vecs++;
         if (dut_vec !== m_vec()) begin
            errs++;
            $display("FAIL random[%0d] got %h need %h",
                     i, dut_vec, m_vec());
         end
      end
   endtask

   task automatic test_reset_midscan();
      int n;
      mode    = 2'b00;
      sel     = 3'd0;
      tick();
      mode    = 2'b01;
      mask    = 8'hFF;
      dwell   = 8'd0;
      step_en = 1'b1;
      n       = 0;
      do begin
         in_bus = $urandom;
         tick();
         n++;
      end while (m_ch != 4 && n < 20);
      vecs++;
      if (n >= 20 || dut_vec !== m_vec()) begin
         errs++;
         $display("FAIL rst_reach got %h need %h", dut_vec, m_vec());
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      vecs++;
      if (dut_vec !== 9'd0) begin
         errs++;
         $display("FAIL rst_async got %h need 000", dut_vec);
      end
      #4;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         logic [SW-1:0] ec;
         in_bus = $urandom;
         ec     = SW'(i);
         tick();
         vecs++;
         if (ch !== ec || dut_vec !== m_vec()) begin
            errs++;
            $display("FAIL rst_resume[%0d] got %h need ch %0d vec %h",
                     i, dut_vec, ec, m_vec());
         end
      end
   endtask

   task automatic test_fixed_range();
      logic [3:0] keep6;
      mode  = 2'b00;
      in10  = {$urandom, 8'($urandom)};
      in6   = 24'($urandom);
      sel10 = 4'd9;
      sel6  = 3'd5;
      tick();
      keep6 = in6[23:20];
      vecs++;
      if ({out10, ch10, vld10} !== {in10[39:36], 4'd9, 1'b1}) begin
         errs++;
         $display("FAIL n10_sel9 got %h need %h",
                  {out10, ch10, vld10}, {in10[39:36], 4'd9, 1'b1});
      end
      vecs++;
      if ({out6, ch6, vld6} !== {keep6, 3'd5, 1'b1}) begin
         errs++;
         $display("FAIL n6_sel5 got %h need %h",
                  {out6, ch6, vld6}, {keep6, 3'd5, 1'b1});
      end
      sel6 = 3'd7;
      in6  = ~in6;
      tick();
      vecs++;
      if ({out6, ch6, vld6, wrap6} !== {keep6, 3'd5, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL n6_sel7 got %h need %h",
                  {out6, ch6, vld6, wrap6}, {keep6, 3'd5, 2'b00});
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fixed();
      test_scan_up();
      test_scan_down();
      test_mask_zero();
      test_step_hold();
      test_dwell_change();
      test_random();
      test_reset_midscan();
      test_fixed_range();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d vectors", vecs);
      $fatal(1, "timeout");
   end

endmodule
